// File: rtl/demux1to4_16bit_buf_pkg.sv
// Shared constants and helpers for the buffered 1-to-4 demux.
// Defaults for word width and per-channel FIFO depth, plus the select decoder.
package demux1to4_16bit_buf_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 2;
    localparam int NUM_CHAN  = 4;
    localparam int SEL_W     = 2;

    function automatic logic [NUM_CHAN-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NUM_CHAN'(1) << sel;
    endfunction

endpackage

// File: rtl/demux1to4_16bit_buf_chan_fifo.sv
// Per-channel FIFO: DEPTH entries, power-of-two pointers, registered occupancy.
// Latency: a pushed word is visible on head_data after the push edge.
// Backpressure: push is ignored when full and pop is ignored when empty; full does not consider a same-cycle pop.
module demux_chan_fifo
    import demux1to4_16bit_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrptr;
    logic [AW-1:0]    rdptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrptr <= '0;
            rdptr <= '0;
            count <= '0;
        end else begin
            if (push_ok) wrptr <= wrptr + AW'(1);
            if (pop_ok)  rdptr <= rdptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && rst_n) mem[wrptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rdptr];

endmodule

// File: rtl/demux1to4_16bit_buf.sv
// Buffered 1-to-4 demux: each input word is steered by in_sel into one of four FIFOs.
// Latency: one cycle from acceptance to out_valid/out_data on the selected channel.
// Backpressure: in_ready = !full[in_sel], independent of out_ready; each channel drains on its own handshake.
module demux1to4_16bit_buf
    import demux1to4_16bit_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [SEL_W-1:0]    in_sel,
    output logic [NUM_CHAN-1:0] out_valid,
    input  logic [NUM_CHAN-1:0] out_ready,
    output logic [WIDTH-1:0]    out_data0,
    output logic [WIDTH-1:0]    out_data1,
    output logic [WIDTH-1:0]    out_data2,
    output logic [WIDTH-1:0]    out_data3
);

    logic [NUM_CHAN-1:0] full;
    logic [NUM_CHAN-1:0] empty;
    logic [NUM_CHAN-1:0] push_vec;
    logic [NUM_CHAN-1:0] pop_vec;
    logic [WIDTH-1:0]    head [NUM_CHAN];

    assign in_ready  = !full[in_sel];
    assign push_vec  = (in_valid && in_ready) ? sel_onehot(in_sel) : '0;
    assign out_valid = ~empty;
    assign pop_vec   = out_valid & out_ready;

    for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_vec[k]),
            .push_data (in_data),
            .pop       (pop_vec[k]),
            .head_data (head[k]),
            .empty     (empty[k]),
            .full      (full[k])
        );
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

endmodule

// File: tb/tb_demux1to4_16bit_buf.sv
// Directed plus randomized bench for the buffered 1-to-4 demux.
// Outputs are compared every cycle against four reference queues.
module tb_demux1to4_16bit_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data0, out_data1, out_data2, out_data3;

    demux1to4_16bit_buf #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3)
    );

    always #5 clk = ~clk;

    logic [15:0] q [4][$];
    int          n_total = 0;
    int          n_fail  = 0;
    bit          model_known = 1'b0;
    logic        last_rdy;
    logic [3:0]  last_vld;

    function automatic logic [15:0] od(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive, compare against the queues mid-cycle, then apply the edge to the model.
    task automatic cyc(input logic r, input logic v, input logic [1:0] s,
                       input logic [15:0] d, input logic [3:0] ordy);
        logic       e_rdy;
        logic [3:0] e_vld;
        rst_n = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
        @(negedge clk);
        e_rdy = (q[s].size() < DEPTH);
        for (int k = 0; k < 4; k++) e_vld[k] = (q[k].size() != 0);
        last_rdy = in_ready;
        last_vld = out_valid;
        if (model_known) begin
            chk("in_ready", 32'(in_ready), 32'(e_rdy));
            chk("out_valid", 32'(out_valid), 32'(e_vld));
            for (int k = 0; k < 4; k++)
                chk($sformatf("out_data%0d", k), 32'(od(k)),
                    32'(e_vld[k] ? q[k][0] : 16'h0000));
        end
        @(posedge clk);
        if (!r) begin
            for (int k = 0; k < 4; k++) q[k].delete();
            model_known = 1'b1;
        end else if (model_known) begin
            for (int k = 0; k < 4; k++)
                if (e_vld[k] && ordy[k]) void'(q[k].pop_front());
            if (v && e_rdy) q[s].push_back(d);
        end
        #1;
    endtask

    initial begin
        // Reset then route
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 4'hF);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 4'hF);
        chk("rst_vld", 32'(out_valid), 32'h0);
        chk("rst_rdy", 32'(in_ready), 32'h1);
        cyc(1'b1, 1'b1, 2'd0, 16'h1111, 4'hF);
        chk("route0_vld", 32'(out_valid), 32'h1);
        chk("route0_dat", 32'(out_data0), 32'h1111);
        cyc(1'b1, 1'b1, 2'd1, 16'h2222, 4'hF);
        cyc(1'b1, 1'b1, 2'd2, 16'h3333, 4'hF);
        cyc(1'b1, 1'b1, 2'd3, 16'h4444, 4'hF);
        chk("route3_dat", 32'(out_data3), 32'h4444);
        cyc(1'b1, 1'b0, 2'd0, 16'h0, 4'hF);
        chk("route_drained", 32'(out_valid), 32'h0);

        // Fill and backpressure on channel 2
        cyc(1'b1, 1'b1, 2'd2, 16'hA001, 4'b1011);
        cyc(1'b1, 1'b1, 2'd2, 16'hA002, 4'b1011);
        cyc(1'b1, 1'b1, 2'd2, 16'hA003, 4'b1011);
        chk("fill_third_rdy", 32'(last_rdy), 32'h0);
        cyc(1'b1, 1'b1, 2'd2, 16'hA003, 4'hF);
        chk("full_pop_rdy", 32'(last_rdy), 32'h0);
        cyc(1'b1, 1'b1, 2'd2, 16'hA003, 4'hF);
        chk("rdy_after_pop", 32'(last_rdy), 32'h1);
        chk("fill_head2", 32'(out_data2), 32'hA003);
        cyc(1'b1, 1'b0, 2'd0, 16'h0, 4'hF);
        chk("fill_drained", 32'(out_valid), 32'h0);

        // Simultaneous push/pop on channel 1
        cyc(1'b1, 1'b1, 2'd1, 16'h1234, 4'h0);
        cyc(1'b1, 1'b1, 2'd1, 16'hBEEF, 4'b0010);
        chk("pp_vld", 32'(out_valid), 32'h2);
        chk("pp_head", 32'(out_data1), 32'hBEEF);
        cyc(1'b1, 1'b0, 2'd1, 16'h0, 4'h0);
        cyc(1'b1, 1'b0, 2'd1, 16'h0, 4'hF);
        chk("pp_drained", 32'(out_valid), 32'h0);

        // Channel 0 full does not block channel 3
        cyc(1'b1, 1'b1, 2'd0, 16'h0A0A, 4'b1110);
        cyc(1'b1, 1'b1, 2'd0, 16'h0B0B, 4'b1110);
        cyc(1'b1, 1'b1, 2'd3, 16'h5555, 4'b1110);
        chk("indep_rdy", 32'(last_rdy), 32'h1);
        chk("indep_dat3", 32'(out_data3), 32'h5555);
        cyc(1'b1, 1'b0, 2'd0, 16'h0, 4'b1110);
        chk("indep_ch0_head", 32'(out_data0), 32'h0A0A);
        chk("indep_vld", 32'(out_valid), 32'h1);

        // Reset mid-operation with channels 0 and 3 full
        cyc(1'b1, 1'b1, 2'd3, 16'h3A3A, 4'h0);
        cyc(1'b1, 1'b1, 2'd3, 16'h3B3B, 4'h0);
        cyc(1'b0, 1'b1, 2'd0, 16'hDEAD, 4'hF);
        chk("midrst_vld", 32'(out_valid), 32'h0);
        chk("midrst_d0", 32'(out_data0), 32'h0);
        chk("midrst_d3", 32'(out_data3), 32'h0);
        cyc(1'b1, 1'b1, 2'd0, 16'h7777, 4'h0);
        chk("post_rst_d0", 32'(out_data0), 32'h7777);
        cyc(1'b1, 1'b0, 2'd0, 16'h0, 4'hF);
        cyc(1'b1, 1'b0, 2'd0, 16'h0, 4'hF);
        chk("post_rst_empty", 32'(out_valid), 32'h0);

        // Random soak against the reference queues
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, ($urandom_range(3) != 0), 2'($urandom_range(3)),
                16'($urandom), 4'($urandom));
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 2'd0, 16'h0, 4'hF);
        chk("soak_drained", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
